// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle renderer: walk FSM states,
// the erase colour and the supported paddle count.
package paddle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        CLEAR,
        DRAW,
        NEXT,
        DONE
    } state_e;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam int         MAX_PADDLES  = 4;
    // Wide enough to hold MAX_PADDLES so that "index + 1" never wraps.
    localparam int         IDX_W        = 3;

endpackage

// File: rtl/rect_scanner.sv
// Rasters a W x H rectangle from a given origin, row-major with x fastest,
// one pixel per cycle starting the cycle after start_i.
module rect_scanner #(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int W  = 5,
    parameter int H  = 40
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [XW-1:0] orig_x_i,
    input  logic [YW-1:0] orig_y_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          valid_o,
    output logic          last_o
);

    localparam int CXW = $clog2(W + 1);
    localparam int CYW = $clog2(H + 1);

    logic [CXW-1:0] cx_q, cx_d;
    logic [CYW-1:0] cy_q, cy_d;
    logic           run_q, run_d;

    always_comb begin
        last_o  = run_q && (cx_q == CXW'(W - 1)) && (cy_q == CYW'(H - 1));
        valid_o = run_q;
        x_o     = orig_x_i + XW'(cx_q);
        y_o     = orig_y_i + YW'(cy_q);
        cx_d    = cx_q;
        cy_d    = cy_q;
        run_d   = run_q;
        // A start on the last pixel chains straight into the next rectangle.
        if (start_i) begin
            cx_d  = '0;
            cy_d  = '0;
            run_d = 1'b1;
        end else if (last_o) begin
            cx_d  = '0;
            cy_d  = '0;
            run_d = 1'b0;
        end else if (run_q) begin
            if (cx_q == CXW'(W - 1)) begin
                cx_d = '0;
                cy_d = cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cx_q  <= '0;
            cy_q  <= '0;
            run_q <= 1'b0;
        end else begin
            cx_q  <= cx_d;
            cy_q  <= cy_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/paddle_array.sv
// Moves up to four vertical paddles once per frame tick and re-renders only
// the paddles that moved, erasing the old rectangle before drawing the new.
module paddle_array
    import paddle_pkg::*;
#(
    parameter int NUM_PADDLES     = 2,
    parameter int X_SCREEN_PIXELS = 320,
    parameter int Y_SCREEN_PIXELS = 240,
    parameter int PADDLE_W        = 5,
    parameter int PADDLE_H        = 40,
    parameter int STEP            = 2,
    localparam int XW = $clog2(X_SCREEN_PIXELS),
    localparam int YW = $clog2(Y_SCREEN_PIXELS),
    parameter logic [NUM_PADDLES*XW-1:0] X_POS  = {9'd315, 9'd10},
    parameter logic [NUM_PADDLES*3-1:0]  COLOUR = {3'b100, 3'b001}
) (
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic                      iFrameTick,
    input  logic [NUM_PADDLES-1:0]    iUp,
    input  logic [NUM_PADDLES-1:0]    iDown,
    output logic [XW-1:0]             oX,
    output logic [YW-1:0]             oY,
    output logic [2:0]                oColour,
    output logic                      oPlot,
    output logic                      oFrameDone,
    output logic                      oBusy,
    output logic                      oMissedTick,
    output logic [NUM_PADDLES*YW-1:0] oPaddleY
);

    localparam int             IW      = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1;
    localparam logic [YW-1:0]  Y_MAX   = YW'(Y_SCREEN_PIXELS - PADDLE_H);
    localparam logic [YW-1:0]  Y_RESET = YW'((Y_SCREEN_PIXELS - PADDLE_H) / 2);
    localparam logic [YW:0]    STEP_W  = (YW + 1)'(STEP);

    state_e                             state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [IW-1:0]                      idx_sel;
    logic [NUM_PADDLES-1:0][YW-1:0]     y_q, y_d, old_y_q, old_y_d;
    logic [NUM_PADDLES-1:0]             up_q, up_d, dn_q, dn_d, moved_q, moved_d;
    logic                               first_q, first_d, busy_q, busy_d;
    logic                               done_q, done_d, miss_q, miss_d;
    logic                               plot_q, plot_d;
    logic [XW-1:0]                      x_q, x_d;
    logic [YW-1:0]                      ypix_q, ypix_d;
    logic [2:0]                         colour_q, colour_d;

    logic                               scan_start, scan_valid, scan_last;
    logic [XW-1:0]                      scan_x, orig_x;
    logic [YW-1:0]                      scan_y, orig_y;
    logic                               found;
    logic [IDX_W-1:0]                   found_idx, search_from;

    function automatic logic [YW-1:0] step_y(input logic [YW-1:0] y,
                                              input logic up, input logic dn);
        logic [YW:0] wide;
        wide = {1'b0, y};
        if (up && !dn) begin
            wide = (wide >= STEP_W) ? wide - STEP_W : '0;
        end else if (dn && !up) begin
            wide = (wide + STEP_W >= {1'b0, Y_MAX}) ? {1'b0, Y_MAX} : wide + STEP_W;
        end
        return wide[YW-1:0];
    endfunction

    assign idx_sel = idx_q[IW-1:0];
    assign orig_x  = X_POS[int'(idx_sel)*XW +: XW];
    assign orig_y  = (state_q == CLEAR) ? old_y_q[idx_sel] : y_q[idx_sel];

    rect_scanner #(
        .XW (XW),
        .YW (YW),
        .W  (PADDLE_W),
        .H  (PADDLE_H)
    ) u_scanner (
        .clk_i    (iClock),
        .rst_i    (iReset),
        .start_i  (scan_start),
        .orig_x_i (orig_x),
        .orig_y_i (orig_y),
        .x_o      (scan_x),
        .y_o      (scan_y),
        .valid_o  (scan_valid),
        .last_o   (scan_last)
    );

    // Lowest moved paddle at or after the search point, found in one cycle so
    // unmoved paddles cost no render time.
    always_comb begin
        search_from = (state_q == NEXT) ? '0 : idx_q + 1'b1;
        found       = 1'b0;
        found_idx   = '0;
        for (int i = NUM_PADDLES - 1; i >= 0; i--) begin
            if (moved_q[i] && (IDX_W'(i) >= search_from)) begin
                found     = 1'b1;
                found_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        scan_start = 1'b0;
        up_d       = up_q;
        dn_d       = dn_q;
        y_d        = y_q;
        old_y_d    = old_y_q;
        moved_d    = moved_q;
        first_d    = first_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        miss_d     = iFrameTick && (state_q != IDLE);
        plot_d     = scan_valid;
        x_d        = scan_x;
        ypix_d     = scan_y;
        colour_d   = (state_q == CLEAR) ? COLOUR_BLACK : COLOUR[int'(idx_sel)*3 +: 3];

        case (state_q)
            IDLE: begin
                if (iFrameTick) begin
                    up_d    = iUp;
                    dn_d    = iDown;
                    busy_d  = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                for (int i = 0; i < NUM_PADDLES; i++) begin
                    old_y_d[i] = y_q[i];
                    y_d[i]     = step_y(y_q[i], up_q[i], dn_q[i]);
                    moved_d[i] = (y_d[i] != y_q[i]) | first_q;
                end
                state_d = NEXT;
            end
            CLEAR: begin
                if (scan_last) begin
                    scan_start = 1'b1;
                    state_d    = DRAW;
                end
            end
            NEXT, DRAW: begin
                if ((state_q == NEXT) || scan_last) begin
                    if (found) begin
                        idx_d      = found_idx;
                        scan_start = 1'b1;
                        state_d    = first_q ? DRAW : CLEAR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                first_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            idx_q    <= '0;
            up_q     <= '0;
            dn_q     <= '0;
            y_q      <= {NUM_PADDLES{Y_RESET}};
            old_y_q  <= {NUM_PADDLES{Y_RESET}};
            moved_q  <= '0;
            first_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            miss_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            ypix_q   <= '0;
            colour_q <= '0;
        end else begin
            idx_q    <= idx_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            y_q      <= y_d;
            old_y_q  <= old_y_d;
            moved_q  <= moved_d;
            first_q  <= first_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            miss_q   <= miss_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            ypix_q   <= ypix_d;
            colour_q <= colour_d;
        end
    end

    assign oX          = x_q;
    assign oY          = ypix_q;
    assign oColour     = colour_q;
    assign oPlot       = plot_q;
    assign oFrameDone  = done_q;
    assign oBusy       = busy_q;
    assign oMissedTick = miss_q;
    assign oPaddleY    = y_q;

endmodule
